alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the processor execute stage. It keeps the existing 4-bit operation encoding and adds a registered result, a start/busy/done handshake and iterative signed/unsigned multiply and divide producing HI/LO results. Single-cycle operations complete one clock after start. Multiply and divide take WIDTH+1 clocks, so the pipeline control stalls on busy_o.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq_muldiv.sv | 79 +++++++
 rtl/alu_seq.sv | 115 +++++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state type and op classification helpers for alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] ALU_AND     = 4'd0;
    localparam logic [3:0] ALU_OR      = 4'd1;
    localparam logic [3:0] ALU_ADD     = 4'd2;
    localparam logic [3:0] ALU_SUB     = 4'd3;
    localparam logic [3:0] ALU_SLT     = 4'd4;
    localparam logic [3:0] ALU_SLTU    = 4'd5;
    localparam logic [3:0] ALU_BNEZ    = 4'd6;
    localparam logic [3:0] ALU_SLL     = 4'd7;
    localparam logic [3:0] ALU_SLLV    = 4'd8;
    localparam logic [3:0] ALU_LUI     = 4'd9;
    localparam logic [3:0] ALU_ORI     = 4'd10;
    localparam logic [3:0] ALU_MULT    = 4'd11;
    localparam logic [3:0] ALU_PC_ADD4 = 4'd12;
    localparam logic [3:0] ALU_MULTU   = 4'd13;
    localparam logic [3:0] ALU_DIV     = 4'd14;
    localparam logic [3:0] ALU_DIVU    = 4'd15;

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the execute-stage control and alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);
    localparam int SHW = $clog2(WIDTH);

    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [SHW-1:0]   shamt_i;
    logic [WIDTH-1:0] pc_add4_i;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] hi_o;
    logic             zero_o;
    logic             busy_o;
    logic             done_o;
    logic             div_by_zero_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i, shamt_i, pc_add4_i,
        input  result_o, hi_o, zero_o, busy_o, done_o, div_by_zero_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i, shamt_i, pc_add4_i,
        output result_o, hi_o, zero_o, busy_o, done_o, div_by_zero_o
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand magnitudes,
// with the sign fix-up applied to the final step's value so the FSM can register it directly.
module seq_muldiv #(parameter int WIDTH = 32) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic             mul_op,
    input  logic             neg_x,
    input  logic             neg_r,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);
    localparam int CW = $clog2(WIDTH);

    // hi_q: product high half / partial remainder; lo_q: multiplier / dividend-then-quotient
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CW-1:0]    count;
    logic             mul_q, neg_x_q, neg_r_q;

    logic [WIDTH:0]     sum, shifted, diff;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (mul_q) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], lo_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            nxt_hi = diff[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
        prod = {nxt_hi, nxt_lo};
        if (neg_x_q)
            prod = -prod;
        if (mul_q) begin
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = neg_x_q ? -nxt_lo : nxt_lo;
            res_hi = neg_r_q ? -nxt_hi : nxt_hi;
        end
        last = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            count   <= '0;
            mul_q   <= 1'b0;
            neg_x_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (load) begin
            hi_q    <= '0;
            lo_q    <= a_mag;
            b_q     <= b_mag;
            count   <= '0;
            mul_q   <= mul_op;
            neg_x_q <= neg_x;
            neg_r_q <= neg_r;
        end else if (step) begin
            hi_q  <= nxt_hi;
            lo_q  <= nxt_lo;
            count <= finish ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle ops inline, mul/div delegated to seq_muldiv.
//   state | meaning
//   IDLE  | accepts start_i; single-cycle ops and divide-by-zero complete here
//   CALC  | one mul/div iteration per clock, writes HI/LO on the last one
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk_i,
    input logic     rst_i,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] result_q, hi_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH-1:0] single_res, a_mag, b_mag, md_lo, md_hi;
    logic             op_signed, div_zero, load, step, finish, last, mul_op, neg_x, neg_r;

    always_comb begin
        op_signed = is_signed_op(bus.ctrl_i);
        mul_op    = (bus.ctrl_i == ALU_MULT) || (bus.ctrl_i == ALU_MULTU);
        div_zero  = ((bus.ctrl_i == ALU_DIV) || (bus.ctrl_i == ALU_DIVU)) && (bus.src2_i == '0);
        load      = (state == IDLE) && bus.start_i && is_iter_op(bus.ctrl_i) && !div_zero;
        step      = (state == CALC);
        finish    = step && last;
        a_mag     = (op_signed && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
        b_mag     = (op_signed && bus.src2_i[WIDTH-1]) ? -bus.src2_i : bus.src2_i;
        neg_x     = op_signed && (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
        neg_r     = op_signed && bus.src1_i[WIDTH-1];
    end

    // default arm is only reached by divide-by-zero; other iterative codes always load
    always_comb begin
        case (bus.ctrl_i)
            ALU_AND:     single_res = bus.src1_i & bus.src2_i;
            ALU_OR:      single_res = bus.src1_i | bus.src2_i;
            ALU_ADD:     single_res = bus.src1_i + bus.src2_i;
            ALU_SUB:     single_res = bus.src1_i - bus.src2_i;
            ALU_SLT:     single_res = WIDTH'($signed(bus.src1_i) < $signed(bus.src2_i));
            ALU_SLTU:    single_res = WIDTH'(bus.src1_i < bus.src2_i);
            ALU_BNEZ:    single_res = bus.src1_i;
            ALU_SLL:     single_res = bus.src2_i << bus.shamt_i;
            ALU_SLLV:    single_res = bus.src2_i << bus.src1_i[SHW-1:0];
            ALU_LUI:     single_res = WIDTH'({bus.src2_i[15:0], 16'h0000});
            ALU_ORI:     single_res = bus.src1_i | WIDTH'(bus.src2_i[15:0]);
            ALU_PC_ADD4: single_res = bus.pc_add4_i;
            default:     single_res = '1;
        endcase
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (load),
        .step   (step),
        .finish (finish),
        .mul_op (mul_op),
        .neg_x  (neg_x),
        .neg_r  (neg_r),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .last   (last),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                    end else if (bus.start_i) begin
                        result_q <= single_res;
                        done_q   <= 1'b1;
                        dbz_q    <= div_zero;
                        if (div_zero)
                            hi_q <= bus.src1_i;
                    end
                end
                CALC: begin
                    if (last) begin
                        state    <= IDLE;
                        result_q <= md_lo;
                        hi_q     <= md_hi;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_o      = result_q;
    assign bus.hi_o          = hi_q;
    assign bus.zero_o        = (result_q == '0);
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, handshake/reset corner cases, random vs. model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] pc, res, hi;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] sh,
                                input logic [31:0] pc, res, hi, input logic dbz, input int lat);
        vec_t v;
        v.c = c; v.a = a; v.b = b; v.sh = sh; v.pc = pc;
        v.res = res; v.hi = hi; v.dbz = dbz; v.lat = lat;
        vt.push_back(v);
    endfunction

    // Arithmetic reference: 64-bit integer maths on the architectural definition of each op
    function automatic void model(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] sh,
                                  input logic [31:0] pc, inout logic [31:0] hi,
                                  output logic [31:0] res, output logic dbz, output int lat);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] p;
        dbz = 1'b0;
        lat = 1;
        res = '0;
        case (c)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2:  res = a + b;
            4'd3:  res = a - b;
            4'd4:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  res = (a < b) ? 32'd1 : 32'd0;
            4'd6:  res = a;
            4'd7:  res = b << sh;
            4'd8:  res = b << a[4:0];
            4'd9:  res = {b[15:0], 16'h0000};
            4'd10: res = a | {16'h0000, b[15:0]};
            4'd12: res = pc;
            4'd11, 4'd13: begin
                p = (c == 4'd11) ? 64'(sa * sb) : 64'(a) * 64'(b);
                res = p[31:0];
                hi  = p[63:32];
                lat = 33;
            end
            default: begin
                if (b == 0) begin
                    res = 32'hFFFF_FFFF;
                    hi  = a;
                    dbz = 1'b1;
                end else if (c == 4'd14) begin
                    res = 32'(sa / sb);
                    hi  = 32'(sa % sb);
                    lat = 33;
                end else begin
                    res = a / b;
                    hi  = a % b;
                    lat = 33;
                end
            end
        endcase
    endfunction

    task automatic drive(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] sh, input logic [31:0] pc);
        bus.ctrl_i    = c;
        bus.src1_i    = a;
        bus.src2_i    = b;
        bus.shamt_i   = sh;
        bus.pc_add4_i = pc;
    endtask

    task automatic run(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] sh, input logic [31:0] pc,
                       output logic [31:0] res, hi, output logic dbz, zero, busy_first, one_pulse, output int lat);
        @(negedge clk);
        drive(c, a, b, sh, pc);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        busy_first = bus.busy_o;
        lat = 1;
        while (!bus.done_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res  = bus.result_o;
        hi   = bus.hi_o;
        dbz  = bus.div_by_zero_o;
        zero = bus.zero_o;
        @(negedge clk);
        one_pulse = !bus.done_o;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_result"}, 64'(bus.result_o), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi_o), 64'd0);
        check({tag, "_zero"}, 64'(bus.zero_o), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_done"}, 64'(bus.done_o), 64'd0);
        check({tag, "_dbz"}, 64'(bus.div_by_zero_o), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, hi, mhi, mres, a, b, pc;
        logic        dbz, zero, busy_first, one_pulse, mdbz;
        logic [3:0]  c;
        logic [4:0]  sh;
        int          lat, mlat, ndone;

        bus.start_i = 1'b0;
        drive(4'd0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check_reset_vals("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_released");

        add(ALU_ADD,     32'd7,         32'hFFFF_FFFD, 5'd0, 32'd0,     32'd4,         32'd0,         1'b0, 1);
        add(ALU_SUB,     32'd5,         32'd5,         5'd0, 32'd0,     32'd0,         32'd0,         1'b0, 1);
        add(ALU_AND,     32'hF0F0,      32'hFF00,      5'd0, 32'd0,     32'hF000,      32'd0,         1'b0, 1);
        add(ALU_OR,      32'd1,         32'd2,         5'd0, 32'd0,     32'd3,         32'd0,         1'b0, 1);
        add(ALU_MULT,    32'hFFFF_FFFD, 32'd5,         5'd0, 32'd0,     32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 33);
        add(ALU_SLT,     32'hFFFF_FFFF, 32'd1,         5'd0, 32'd0,     32'd1,         32'hFFFF_FFFF, 1'b0, 1);
        add(ALU_MULTU,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0,     32'd1,         32'hFFFF_FFFE, 1'b0, 33);
        add(ALU_SLTU,    32'hFFFF_FFFF, 32'd1,         5'd0, 32'd0,     32'd0,         32'hFFFF_FFFE, 1'b0, 1);
        add(ALU_DIV,     32'hFFFF_FFF9, 32'd2,         5'd0, 32'd0,     32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        add(ALU_DIV,     32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0,     32'h8000_0000, 32'd0,         1'b0, 33);
        add(ALU_DIVU,    32'd10,        32'd0,         5'd0, 32'd0,     32'hFFFF_FFFF, 32'd10,        1'b1, 1);
        add(ALU_ADD,     32'd1,         32'd2,         5'd0, 32'd0,     32'd3,         32'd10,        1'b0, 1);
        add(ALU_SLL,     32'd0,         32'd3,         5'd4, 32'd0,     32'h30,        32'd10,        1'b0, 1);
        add(ALU_SLLV,    32'd5,         32'd1,         5'd0, 32'd0,     32'h20,        32'd10,        1'b0, 1);
        add(ALU_LUI,     32'd0,         32'h1234_ABCD, 5'd0, 32'd0,     32'hABCD_0000, 32'd10,        1'b0, 1);
        add(ALU_ORI,     32'hF000_0000, 32'hFFFF_000F, 5'd0, 32'd0,     32'hF000_000F, 32'd10,        1'b0, 1);
        add(ALU_PC_ADD4, 32'd0,         32'd0,         5'd0, 32'h100,   32'h100,       32'd10,        1'b0, 1);
        add(ALU_BNEZ,    32'hDEAD,      32'd0,         5'd0, 32'd0,     32'hDEAD,      32'd10,        1'b0, 1);
        add(ALU_DIVU,    32'd100,       32'd7,         5'd0, 32'd0,     32'd14,        32'd2,         1'b0, 33);
        add(ALU_DIV,     32'd7,         32'hFFFF_FFFE, 5'd0, 32'd0,     32'hFFFF_FFFD, 32'd1,         1'b0, 33);
        add(ALU_DIV,     32'h8000_0000, 32'd0,         5'd0, 32'd0,     32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1);
        add(ALU_SLLV,    32'h3F,        32'd1,         5'd0, 32'd0,     32'h8000_0000, 32'h8000_0000, 1'b0, 1);
        add(ALU_MULT,    32'h12345,     32'd0,         5'd0, 32'd0,     32'd0,         32'd0,         1'b0, 33);

        foreach (vt[i]) begin
            run(vt[i].c, vt[i].a, vt[i].b, vt[i].sh, vt[i].pc, res, hi, dbz, zero, busy_first, one_pulse, lat);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vt[i].res));
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vt[i].hi));
            check($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vt[i].dbz));
            check($sformatf("vec%0d_zero", i), 64'(zero), 64'(vt[i].res == 32'd0));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_busy", i), 64'(busy_first), 64'(vt[i].lat > 1));
            check($sformatf("vec%0d_single_pulse", i), 64'(one_pulse), 64'd1);
        end

        // start_i held high with ADD queued behind a DIVU: accepted only in the done cycle
        @(negedge clk);
        drive(ALU_DIVU, 32'd100, 32'd7, 5'd0, 32'd0);
        bus.start_i = 1'b1;
        @(negedge clk);
        drive(ALU_ADD, 32'd1, 32'd2, 5'd0, 32'd0);
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done_o) begin
                ndone++;
                if (ndone == 1) begin
                    check("held_divu_latency", 64'(k), 64'd33);
                    check("held_divu_result", 64'(bus.result_o), 64'd14);
                    check("held_divu_hi", 64'(bus.hi_o), 64'd2);
                end else if (ndone == 2) begin
                    check("held_add_latency", 64'(k), 64'd34);
                    check("held_add_result", 64'(bus.result_o), 64'd3);
                    check("held_add_hi", 64'(bus.hi_o), 64'd2);
                end
            end
            if (k == 34)
                bus.start_i = 1'b0;
            @(negedge clk);
        end
        check("held_done_count", 64'(ndone), 64'd2);

        // reset pulse at iteration 10 of a MULT aborts it without a done pulse
        run(ALU_ADD, 32'h11, 32'h22, 5'd0, 32'd0, res, hi, dbz, zero, busy_first, one_pulse, lat);
        check("pre_rst_result", 64'(res), 64'h33);
        @(negedge clk);
        drive(ALU_MULT, 32'd7, 32'd9, 5'd0, 32'd0);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_mult_busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o)
                ndone++;
        end
        check("post_rst_no_activity", 64'(ndone), 64'd0);
        run(ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd0, res, hi, dbz, zero, busy_first, one_pulse, lat);
        check("post_rst_add_result", 64'(res), 64'd5);
        check("post_rst_add_latency", 64'(lat), 64'd1);
        check("post_rst_add_hi", 64'(hi), 64'd0);

        // random ops against the arithmetic model
        mhi = 32'd0;
        for (int i = 0; i < 40; i++) begin
            c  = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            sh = 5'($urandom_range(0, 31));
            pc = $urandom;
            if ($urandom_range(0, 5) == 0)
                b = 32'd0;
            else if ($urandom_range(0, 3) == 0)
                b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 9)) : -32'($urandom_range(1, 9));
            if ($urandom_range(0, 7) == 0)
                a = 32'h8000_0000;
            model(c, a, b, sh, pc, mhi, mres, mdbz, mlat);
            run(c, a, b, sh, pc, res, hi, dbz, zero, busy_first, one_pulse, lat);
            check($sformatf("rnd%0d_op%0d_result", i, c), 64'(res), 64'(mres));
            check($sformatf("rnd%0d_op%0d_hi", i, c), 64'(hi), 64'(mhi));
            check($sformatf("rnd%0d_op%0d_dbz", i, c), 64'(dbz), 64'(mdbz));
            check($sformatf("rnd%0d_op%0d_latency", i, c), 64'(lat), 64'(mlat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
